tspi_xfer_ctrl: RTL

TSPI_XFER_CTRL -- requirements
Module: tspi_xfer_ctrl

---
 rtl/tspi_xfer_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/tspi_xfer_ctrl.sv
// rtl/tspi_xfer_ctrl.sv - tspi command/response transfer controller
// Optional start-bit timeout enabled by defining TSPI_XFER_TIMEOUT_EN.
module tspi_xfer_ctrl #(
  parameter int ClkDiv       = 4,
  parameter int TimeoutEdges = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_data_i,
  input  logic [5:0]  req_len_i,
  input  logic [5:0]  req_rsp_len_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        tspi_clk_o,
  output logic        new_cmd_o,
  output logic        en_write_o,
  output logic [5:0]  len_cmd_o,
  output logic [31:0] sr_data_o,
  input  logic        start_bit_i,
  input  logic [31:0] sr_data_i,
  output logic        busy_o
);

  if (ClkDiv < 1 || ClkDiv > 255) begin : g_bad_clk_div
    $error("tspi_xfer_ctrl: ClkDiv must be 1..255");
  end
  if (TimeoutEdges < 1 || TimeoutEdges > 65535) begin : g_bad_timeout
    $error("tspi_xfer_ctrl: TimeoutEdges must be 1..65535");
  end

  localparam logic [7:0] DivLast = 8'(ClkDiv - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, RECV, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        tspi_clk_q, tspi_clk_d;
  logic        rise_q, rise_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] data_q, data_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  rsp_len_q, rsp_len_d;
  logic        new_cmd_q, new_cmd_d;
  logic        en_write_q, en_write_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] rsp_mask;
`ifdef TSPI_XFER_TIMEOUT_EN
  localparam logic [15:0] ToLast = 16'(TimeoutEdges - 1);
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        rsp_err_q, rsp_err_d;
`endif

  // Responses longer than the 32-bit data path keep every bit.
  assign rsp_mask = (rsp_len_q >= 6'd32) ? 32'hFFFF_FFFF
                                         : ((32'd1 << rsp_len_q[4:0]) - 32'd1);

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    tspi_clk_d  = tspi_clk_q;
    rise_d      = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    len_d       = len_q;
    rsp_len_d   = rsp_len_q;
    new_cmd_d   = new_cmd_q;
    en_write_d  = en_write_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef TSPI_XFER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    if (state_q == SEND || state_q == WAIT_START || state_q == RECV) begin
      if (div_cnt_q == DivLast) begin
        div_cnt_d  = 8'd0;
        tspi_clk_d = ~tspi_clk_q;
        rise_d     = ~tspi_clk_q;
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d    = SEND;
          data_d     = req_data_i;
          len_d      = req_len_i;
          rsp_len_d  = req_rsp_len_i;
          div_cnt_d  = 8'd0;
          bit_cnt_d  = 6'd0;
          new_cmd_d  = 1'b1;
          en_write_d = 1'b1;
`ifdef TSPI_XFER_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
        end
      end
      SEND: begin
        if (rise_q) begin
          new_cmd_d = 1'b0;
          if (bit_cnt_q == len_q) begin
            en_write_d = 1'b0;
            if (rsp_len_q != 6'd0) begin
              state_d = WAIT_START;
`ifdef TSPI_XFER_TIMEOUT_EN
              to_cnt_d = 16'd0;
`endif
            end else begin
              state_d     = DONE;
              rsp_data_d  = 32'd0;
              rsp_valid_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      WAIT_START: begin
        if (rise_q) begin
          if (start_bit_i) begin
            state_d   = RECV;
            bit_cnt_d = 6'd0;
          end
`ifdef TSPI_XFER_TIMEOUT_EN
          else if (to_cnt_q == ToLast) begin
            state_d     = DONE;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'd0;
            rsp_valid_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
`endif
        end
      end
      RECV: begin
        if (rise_q) begin
          if (bit_cnt_q == rsp_len_q - 6'd1) begin
            state_d     = DONE;
            rsp_data_d  = sr_data_i & rsp_mask;
            rsp_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // The tspi clock parks low whenever the transfer is not shifting.
    if (state_d == IDLE || state_d == DONE) begin
      div_cnt_d  = 8'd0;
      tspi_clk_d = 1'b0;
      rise_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      div_cnt_q   <= 8'd0;
      tspi_clk_q  <= 1'b0;
      rise_q      <= 1'b0;
      bit_cnt_q   <= 6'd0;
      data_q      <= 32'd0;
      len_q       <= 6'd0;
      rsp_len_q   <= 6'd0;
      new_cmd_q   <= 1'b0;
      en_write_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
`ifdef TSPI_XFER_TIMEOUT_EN
      to_cnt_q    <= 16'd0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      tspi_clk_q  <= tspi_clk_d;
      rise_q      <= rise_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      len_q       <= len_d;
      rsp_len_q   <= rsp_len_d;
      new_cmd_q   <= new_cmd_d;
      en_write_q  <= en_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef TSPI_XFER_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign tspi_clk_o  = tspi_clk_q;
  assign new_cmd_o   = new_cmd_q;
  assign en_write_o  = en_write_q;
  assign sr_data_o   = data_q;
  assign len_cmd_o   = len_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
`ifdef TSPI_XFER_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule
